// File: rtl/FetchUnitTypes.sv
// Shared types for the PHT update path: counter type, queue entry, FSM states.
package FetchUnitTypes;

    typedef logic [1:0] pht_entry_t;

    localparam pht_entry_t PHT_INIT_VALUE = 2'b10;
    localparam int PHT_IDX_MAX_W = 16;

    typedef struct packed {
        logic [PHT_IDX_MAX_W-1:0] index;
        pht_entry_t               value;
    } pht_upd_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } fsm_state_t;

    function automatic pht_entry_t sat_update(
        input pht_entry_t c,
        input logic       taken
    );
        if (taken) begin
            return (c == 2'b11) ? c : c + 2'b01;
        end
        return (c == 2'b00) ? c : c - 2'b01;
    endfunction

endpackage

// File: rtl/pht_update_queue.sv
// Two-in / one-out circular FIFO holding pending PHT writes.
module pht_update_queue
    import FetchUnitTypes::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enq0,
    input  logic                   enq1,
    input  pht_upd_t               enq0_data,
    input  pht_upd_t               enq1_data,
    input  logic                   deq,
    output logic [$clog2(DEPTH):0] free_slots,
    output logic                   empty,
    output pht_upd_t               head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    pht_upd_t      mem_q [DEPTH];
    pht_upd_t      mem_d [DEPTH];
    logic [PW-1:0] head_q;
    logic [PW-1:0] head_d;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] tail_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // enq1 is only ever raised together with enq0, so it lands at tail+1.
    always_comb begin
        mem_d  = mem_q;
        tail_d = tail_q;
        if (enq0) begin
            mem_d[tail_q] = enq0_data;
            tail_d        = tail_q + PW'(1);
        end
        if (enq1) begin
            mem_d[tail_q + PW'(1)] = enq1_data;
            tail_d                 = tail_q + PW'(2);
        end
        head_d  = deq ? head_q + PW'(1) : head_q;
        count_d = count_q + CW'(enq0) + CW'(enq1) - CW'(deq);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
        mem_q <= mem_d;
    end

    assign free_slots = CW'(DEPTH) - count_q;
    assign empty      = (count_q == '0);
    assign head       = mem_q[head_q];

endmodule

// File: rtl/branch_predictor_update_scheduler.sv
// Owns the PHT write port: reset-time init sweep, then queued commit updates.
module branch_predictor_update_scheduler
    import FetchUnitTypes::*;
#(
    parameter int         PHT_INDEX_WIDTH = 10,
    parameter int         QUEUE_DEPTH     = 8,
    parameter pht_entry_t INIT_VALUE      = PHT_INIT_VALUE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [1:0]                      updateValid,
    input  logic [1:0][PHT_INDEX_WIDTH-1:0] updateIndex,
    input  logic [1:0]                      updateTaken,
    input  logic [1:0][1:0]                 updateCounter,
    output logic                            initDone,
    output logic                            phtWE,
    output logic [PHT_INDEX_WIDTH-1:0]      phtWA,
    output logic [1:0]                      phtWV,
    output logic [7:0]                      dropCount
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [PHT_INDEX_WIDTH-1:0] SWEEP_LAST = '1;

    fsm_state_t                 state_q;
    fsm_state_t                 state_d;
    logic [PHT_INDEX_WIDTH-1:0] sweep_q;
    logic [PHT_INDEX_WIDTH-1:0] sweep_d;
    logic [7:0]                 drop_q;
    logic [7:0]                 drop_d;

    logic [CW-1:0] free_slots;
    logic [CW-1:0] free_after;
    logic          q_empty;
    logic          run;
    logic          deq;
    logic          same_idx;
    logic          cand0_v;
    logic          cand1_v;
    logic          enq0;
    logic          enq1;
    pht_upd_t      q_head;
    pht_upd_t      lane0_e;
    pht_upd_t      lane1_e;
    pht_upd_t      cand0;
    pht_upd_t      cand1;
    pht_entry_t    new0;
    pht_entry_t    new1;
    logic [1:0]    n_drop;
    logic [8:0]    drop_sum;
    logic          unused_head_hi;

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + PHT_INDEX_WIDTH'(1);
            if (sweep_q == SWEEP_LAST) begin
                state_d = RUN;
            end
        end
    end

    assign run      = (state_q == RUN);
    assign deq      = run & ~q_empty;
    assign same_idx = (&updateValid) && (updateIndex[0] == updateIndex[1]);
    assign new0     = sat_update(updateCounter[0], updateTaken[0]);
    assign new1     = sat_update(updateCounter[1], updateTaken[1]);

    // A same-index pair collapses into lane 0, chaining lane 1's direction.
    always_comb begin
        lane0_e.index = PHT_IDX_MAX_W'(updateIndex[0]);
        lane0_e.value = same_idx ? sat_update(new0, updateTaken[1]) : new0;
        lane1_e.index = PHT_IDX_MAX_W'(updateIndex[1]);
        lane1_e.value = new1;
    end

    assign cand0_v = run & (|updateValid);
    assign cand1_v = run & (&updateValid) & ~same_idx;
    assign cand0   = updateValid[0] ? lane0_e : lane1_e;
    assign cand1   = lane1_e;

    assign free_after = free_slots + CW'(deq);
    assign enq0       = cand0_v & (free_after != '0);
    assign enq1       = cand1_v & (free_after > CW'(1));

    assign n_drop   = 2'(cand0_v & ~enq0) + 2'(cand1_v & ~enq1);
    assign drop_sum = 9'(drop_q) + 9'(n_drop);
    assign drop_d   = drop_sum[8] ? 8'hff : drop_sum[7:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            sweep_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
            drop_q  <= drop_d;
        end
    end

    pht_update_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .enq0      (enq0),
        .enq1      (enq1),
        .enq0_data (cand0),
        .enq1_data (cand1),
        .deq       (deq),
        .free_slots(free_slots),
        .empty     (q_empty),
        .head      (q_head)
    );

    // Outputs read as reset values while rst is held, so a flush never writes.
    always_comb begin
        initDone  = ~rst & run;
        dropCount = rst ? 8'h00 : drop_q;
        phtWE     = 1'b0;
        phtWA     = '0;
        phtWV     = '0;
        if (!rst) begin
            if (state_q == INIT) begin
                phtWE = 1'b1;
                phtWA = sweep_q;
                phtWV = INIT_VALUE;
            end else if (!q_empty) begin
                phtWE = 1'b1;
                phtWA = q_head.index[PHT_INDEX_WIDTH-1:0];
                phtWV = q_head.value;
            end
        end
    end

    assign unused_head_hi = ^q_head.index;

endmodule
